// File: rtl/preset_config_writer_if.sv
// Register-write command channel between the preset writer and the sensor driver.
interface preset_config_writer_if;
  logic       o_cmd_valid;
  logic       i_cmd_ready;
  logic [7:0] o_cmd_addr;
  logic [7:0] o_cmd_data;

  modport master (
    output o_cmd_valid,
    output o_cmd_addr,
    output o_cmd_data,
    input  i_cmd_ready
  );

  modport slave (
    input  o_cmd_valid,
    input  o_cmd_addr,
    input  o_cmd_data,
    output i_cmd_ready
  );
endinterface

// File: rtl/preset_config_writer.sv
// Streams the selected preset's threshold and timer to the sensor as four byte writes
// whenever the preset index changes (and once after reset).
module preset_config_writer #(
  parameter logic [7:0] parm_thresh_addr = 8'h23,
  parameter logic [7:0] parm_timer_addr  = 8'h25
) (
  input  logic                          i_clk_20mhz,
  input  logic                          i_rst_20mhz,
  input  logic [3:0]                    i_value_enum,
  input  logic [15:0]                   i_value_thresh,
  input  logic [15:0]                   i_value_timer,
  preset_config_writer_if.master        cmd,
  output logic                          o_busy,
  output logic                          o_apply_done,
  output logic [3:0]                    o_applied_enum
);

  // 8-bit localparams so the +1 wraps modulo 256.
  localparam logic [7:0] ThreshHiAddr = parm_thresh_addr + 8'd1;
  localparam logic [7:0] TimerHiAddr  = parm_timer_addr + 8'd1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR_THR_L,
    ST_WR_THR_H,
    ST_WR_TMR_L,
    ST_WR_TMR_H,
    ST_DONE
  } state_e;

  state_e      r_state;
  logic        r_first;
  logic [3:0]  r_snap_enum;
  logic [10:0] r_snap_thresh;
  logic [15:0] r_snap_timer;
  logic        xfer;

  // The sensor only holds an 11-bit threshold; the top bits are dropped on purpose.
  logic unused_thresh_hi;
  assign unused_thresh_hi = ^i_value_thresh[15:11];

  assign xfer = cmd.o_cmd_valid && cmd.i_cmd_ready;

  always_ff @(posedge i_clk_20mhz) begin
    if (i_rst_20mhz) begin
      r_state         <= ST_IDLE;
      r_first         <= 1'b1;
      r_snap_enum     <= 4'h0;
      r_snap_thresh   <= 11'h000;
      r_snap_timer    <= 16'h0000;
      cmd.o_cmd_valid <= 1'b0;
      cmd.o_cmd_addr  <= 8'h00;
      cmd.o_cmd_data  <= 8'h00;
      o_busy          <= 1'b0;
      o_apply_done    <= 1'b0;
      o_applied_enum  <= 4'h0;
    end else begin
      o_apply_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (r_first || (i_value_enum != r_snap_enum)) begin
            r_snap_enum     <= i_value_enum;
            r_snap_thresh   <= i_value_thresh[10:0];
            r_snap_timer    <= i_value_timer;
            r_first         <= 1'b0;
            r_state         <= ST_WR_THR_L;
            cmd.o_cmd_valid <= 1'b1;
            cmd.o_cmd_addr  <= parm_thresh_addr;
            cmd.o_cmd_data  <= i_value_thresh[7:0];
            o_busy          <= 1'b1;
          end
        end
        ST_WR_THR_L: begin
          if (xfer) begin
            r_state        <= ST_WR_THR_H;
            cmd.o_cmd_addr <= ThreshHiAddr;
            cmd.o_cmd_data <= {5'b0, r_snap_thresh[10:8]};
          end
        end
        ST_WR_THR_H: begin
          if (xfer) begin
            r_state        <= ST_WR_TMR_L;
            cmd.o_cmd_addr <= parm_timer_addr;
            cmd.o_cmd_data <= r_snap_timer[7:0];
          end
        end
        ST_WR_TMR_L: begin
          if (xfer) begin
            r_state        <= ST_WR_TMR_H;
            cmd.o_cmd_addr <= TimerHiAddr;
            cmd.o_cmd_data <= r_snap_timer[15:8];
          end
        end
        ST_WR_TMR_H: begin
          if (xfer) begin
            r_state         <= ST_DONE;
            cmd.o_cmd_valid <= 1'b0;
            o_apply_done    <= 1'b1;
            o_applied_enum  <= r_snap_enum;
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
          o_busy  <= 1'b0;
        end
        default: begin
          r_state         <= ST_IDLE;
          cmd.o_cmd_valid <= 1'b0;
          o_busy          <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_preset_config_writer.sv
// Scoreboard bench: expected writes/completions are queued as stimulus is applied and
// checked by a monitor as the DUT transfers them.
module tb_preset_config_writer;

  logic        clk = 1'b0;
  logic        rst;
  logic        ready;
  logic [3:0]  value_enum;
  logic [15:0] value_thresh;
  logic [15:0] value_timer;

  logic        busy, apply_done;
  logic [3:0]  applied_enum;
  logic        busy2, apply_done2;
  logic [3:0]  applied_enum2;

  int checks = 0;
  int errors = 0;
  int done_count = 0;

  typedef struct packed {
    logic [7:0] addr;
    logic [7:0] data;
  } wr_t;

  wr_t        exp_wr_q[$];
  logic [3:0] exp_enum_q[$];
  wr_t        mon_exp;
  logic [3:0] mon_enum;

  preset_config_writer_if cmd_if ();
  preset_config_writer_if cmd_if2 ();
  assign cmd_if.i_cmd_ready  = ready;
  assign cmd_if2.i_cmd_ready = ready;

  preset_config_writer dut (
    .i_clk_20mhz    (clk),
    .i_rst_20mhz    (rst),
    .i_value_enum   (value_enum),
    .i_value_thresh (value_thresh),
    .i_value_timer  (value_timer),
    .cmd            (cmd_if.master),
    .o_busy         (busy),
    .o_apply_done   (apply_done),
    .o_applied_enum (applied_enum)
  );

  preset_config_writer #(
    .parm_thresh_addr (8'hFF)
  ) dut_wrap (
    .i_clk_20mhz    (clk),
    .i_rst_20mhz    (rst),
    .i_value_enum   (value_enum),
    .i_value_thresh (value_thresh),
    .i_value_timer  (value_timer),
    .cmd            (cmd_if2.master),
    .o_busy         (busy2),
    .o_apply_done   (apply_done2),
    .o_applied_enum (applied_enum2)
  );

  always #25 clk = ~clk;

  // Monitor on the falling edge: a transfer is valid && ready ahead of the next rising edge.
  always @(negedge clk) begin
    if (!rst && cmd_if.o_cmd_valid && ready) begin
      checks++;
      if (exp_wr_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write got addr=%h data=%h required no write",
                 cmd_if.o_cmd_addr, cmd_if.o_cmd_data);
      end else begin
        mon_exp = exp_wr_q.pop_front();
        if ({cmd_if.o_cmd_addr, cmd_if.o_cmd_data} !== mon_exp) begin
          errors++;
          $display("FAIL write got (%h,%h) required (%h,%h)", cmd_if.o_cmd_addr,
                   cmd_if.o_cmd_data, mon_exp.addr, mon_exp.data);
        end
      end
    end
    if (!rst && apply_done) begin
      done_count++;
      checks++;
      if (exp_enum_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_apply_done got enum=%0d required no pulse", applied_enum);
      end else begin
        mon_enum = exp_enum_q.pop_front();
        if (applied_enum !== mon_enum || busy !== 1'b1) begin
          errors++;
          $display("FAIL apply_done got enum=%0d busy=%b required enum=%0d busy=1",
                   applied_enum, busy, mon_enum);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_wr(input logic [7:0] a, input logic [7:0] d);
    exp_wr_q.push_back({a, d});
  endtask

  task automatic push_seq(input logic [15:0] thr, input logic [15:0] tmr, input logic [3:0] e);
    push_wr(8'h23, thr[7:0]);
    push_wr(8'h24, {5'b0, thr[10:8]});
    push_wr(8'h25, tmr[7:0]);
    push_wr(8'h26, tmr[15:8]);
    exp_enum_q.push_back(e);
  endtask

  task automatic set_inputs(input logic [3:0] e, input logic [15:0] thr, input logic [15:0] tmr);
    value_enum   = e;
    value_thresh = thr;
    value_timer  = tmr;
  endtask

  task automatic wait_valid_addr(input logic [7:0] a);
    bit found = 0;
    for (int i = 0; i < 50 && !found; i++) begin
      step();
      if (cmd_if.o_cmd_valid && cmd_if.o_cmd_addr == a) found = 1;
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL wait_valid_addr got timeout required valid at addr %h", a);
    end
  endtask

  task automatic wait_done(input int target);
    for (int i = 0; i < 100 && done_count < target; i++) step();
    checks++;
    if (done_count < target) begin
      errors++;
      $display("FAIL wait_done got %0d completions required %0d", done_count, target);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    checks++;
    if (cmd_if.o_cmd_valid !== 1'b0 || cmd_if.o_cmd_addr !== 8'h00 ||
        cmd_if.o_cmd_data !== 8'h00 || busy !== 1'b0 || apply_done !== 1'b0 ||
        applied_enum !== 4'h0) begin
      errors++;
      $display("FAIL %s got v=%b a=%h d=%h busy=%b done=%b enum=%0d required all zero", tag,
               cmd_if.o_cmd_valid, cmd_if.o_cmd_addr, cmd_if.o_cmd_data, busy, apply_done,
               applied_enum);
    end
  endtask

  task automatic test_reset();
    rst   = 1'b1;
    ready = 1'b1;
    set_inputs(4'd0, 16'd300, 16'd1000);
    repeat (3) step();
    check_reset_outputs("reset_state");
  endtask

  task automatic test_basic();
    int lat = 0;
    push_wr(8'h23, 8'h2C);
    push_wr(8'h24, 8'h01);
    push_wr(8'h25, 8'hE8);
    push_wr(8'h26, 8'h03);
    exp_enum_q.push_back(4'd0);
    rst = 1'b0;
    for (int i = 1; i <= 20 && lat == 0; i++) begin
      step();
      if (i == 1) begin
        checks++;
        if (cmd_if.o_cmd_valid !== 1'b1 || busy !== 1'b1) begin
          errors++;
          $display("FAIL first_valid got v=%b busy=%b required 1 1", cmd_if.o_cmd_valid, busy);
        end
      end
      if (apply_done) lat = i;
    end
    checks++;
    if (lat != 5) begin
      errors++;
      $display("FAIL basic_latency got %0d cycles required 5", lat);
    end
    step();
    checks++;
    if (apply_done !== 1'b0 || busy !== 1'b0 || cmd_if.o_cmd_valid !== 1'b0 ||
        cmd_if.o_cmd_addr !== 8'h26 || cmd_if.o_cmd_data !== 8'h03) begin
      errors++;
      $display("FAIL idle_after_done got done=%b busy=%b v=%b a=%h d=%h required 0 0 0 26 03",
               apply_done, busy, cmd_if.o_cmd_valid, cmd_if.o_cmd_addr, cmd_if.o_cmd_data);
    end
  endtask

  task automatic test_stall();
    int target = done_count + 1;
    ready = 1'b0;
    set_inputs(4'd1, 16'd300, 16'd1000);
    push_seq(16'd300, 16'd1000, 4'd1);
    wait_valid_addr(8'h23);
    ready = 1'b1;
    step();
    ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      checks++;
      if (cmd_if.o_cmd_valid !== 1'b1 || cmd_if.o_cmd_addr !== 8'h24 ||
          cmd_if.o_cmd_data !== 8'h01) begin
        errors++;
        $display("FAIL stall_hold got v=%b a=%h d=%h required 1 24 01", cmd_if.o_cmd_valid,
                 cmd_if.o_cmd_addr, cmd_if.o_cmd_data);
      end
    end
    ready = 1'b1;
    wait_done(target);
  endtask

  task automatic test_change_mid();
    int target = done_count + 2;
    set_inputs(4'd0, 16'd300, 16'd1000);
    push_seq(16'd300, 16'd1000, 4'd0);
    wait_valid_addr(8'h25);
    set_inputs(4'd3, 16'hFFFF, 16'h0000);
    push_wr(8'h23, 8'hFF);
    push_wr(8'h24, 8'h07);
    push_wr(8'h25, 8'h00);
    push_wr(8'h26, 8'h00);
    exp_enum_q.push_back(4'd3);
    wait_done(target);
    checks++;
    if (applied_enum !== 4'd3) begin
      errors++;
      $display("FAIL change_mid_enum got %0d required 3", applied_enum);
    end
  endtask

  task automatic test_enum_pulse();
    int target = done_count + 1;
    set_inputs(4'd2, 16'h0456, 16'h789A);
    push_seq(16'h0456, 16'h789A, 4'd2);
    wait_valid_addr(8'h23);
    value_enum = 4'd1;
    step();
    step();
    value_enum = 4'd2;
    wait_done(target);
    checks++;
    if (busy !== 1'b0 || apply_done !== 1'b0) begin
      errors++;
      $display("FAIL busy_fall got busy=%b done=%b required 0 0", busy, apply_done);
    end
    for (int i = 0; i < 8; i++) begin
      step();
      checks++;
      if (cmd_if.o_cmd_valid !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL no_restart got v=%b busy=%b required 0 0", cmd_if.o_cmd_valid, busy);
      end
    end
  endtask

  task automatic test_reset_mid();
    int target;
    set_inputs(4'd4, 16'h1234, 16'h5678);
    push_wr(8'h23, 8'h34);
    push_wr(8'h24, 8'h02);
    wait_valid_addr(8'h25);
    rst = 1'b1;
    step();
    check_reset_outputs("reset_mid");
    step();
    target = done_count + 1;
    push_seq(16'h1234, 16'h5678, 4'd4);
    rst = 1'b0;
    wait_done(target);
    checks++;
    if (applied_enum !== 4'd4) begin
      errors++;
      $display("FAIL reset_mid_reapply got %0d required 4", applied_enum);
    end
  endtask

  task automatic test_wrap();
    int target = done_count + 1;
    set_inputs(4'd6, 16'h0A0B, 16'h0C0D);
    push_seq(16'h0A0B, 16'h0C0D, 4'd6);
    wait_valid_addr(8'h23);
    checks++;
    if (cmd_if2.o_cmd_addr !== 8'hFF || cmd_if2.o_cmd_data !== 8'h0B) begin
      errors++;
      $display("FAIL wrap_thr_l got (%h,%h) required (ff,0b)", cmd_if2.o_cmd_addr,
               cmd_if2.o_cmd_data);
    end
    step();
    checks++;
    if (cmd_if2.o_cmd_valid !== 1'b1 || cmd_if2.o_cmd_addr !== 8'h00 ||
        cmd_if2.o_cmd_data !== 8'h02) begin
      errors++;
      $display("FAIL wrap_thr_h got v=%b (%h,%h) required 1 (00,02)", cmd_if2.o_cmd_valid,
               cmd_if2.o_cmd_addr, cmd_if2.o_cmd_data);
    end
    wait_done(target);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_change_mid();
    test_enum_pulse();
    test_reset_mid();
    test_wrap();
    repeat (3) step();
    checks++;
    if (exp_wr_q.size() != 0 || exp_enum_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain got %0d writes %0d completions left required 0 0",
               exp_wr_q.size(), exp_enum_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
